// File: rtl/grant_decoder.sv
// grant_decoder: turns a selected channel index into a registered one-hot grant.
// The grant is held until the granted channel acknowledges, enable drops, or
// reset is applied.
//
// Optional feature: define GRANT_DECODER_TIMEOUT_EN to abandon a grant after
// TIMEOUT unacknowledged GRANT cycles. When it is undefined, timeout is tied 0.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   enable       block enable; low blocks accepts and aborts an active grant
//   sel_valid    request valid, selected carries the channel index
//   selected     channel index 0..7
//   sel_ready    high when a request can be accepted this cycle
//   ack          per-channel acknowledge
//   grant        registered one-hot grant, zero when idle
//   busy         high while a grant is active
//   done         one-cycle pulse on acknowledged completion
//   done_idx     index of the last completed grant
//   timeout      one-cycle pulse when a grant is abandoned
//   stray_ack    sticky: ack seen on a non-granted channel during a grant
//   grant_count  number of completed grants, wraps at 8 bits
module grant_decoder #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sel_valid,
  input  logic [2:0] selected,
  output logic       sel_ready,
  input  logic [7:0] ack,
  output logic [7:0] grant,
  output logic       busy,
  output logic       done,
  output logic [2:0] done_idx,
  output logic       timeout,
  output logic       stray_ack,
  output logic [7:0] grant_count
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : gen_bad_timeout
    $error("grant_decoder: TIMEOUT must be in 2..255");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [2:0] idx_q;
  logic [7:0] grant_q;
  logic       done_q;
  logic [2:0] done_idx_q;
  logic       timeout_q;
  logic       stray_q;
  logic [7:0] count_q;

`ifdef GRANT_DECODER_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);
  logic [7:0] wait_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      grant_q    <= 8'd0;
      done_q     <= 1'b0;
      done_idx_q <= 3'd0;
      timeout_q  <= 1'b0;
      stray_q    <= 1'b0;
      count_q    <= 8'd0;
`ifdef GRANT_DECODER_TIMEOUT_EN
      wait_q     <= 8'd0;
`endif
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sel_valid && enable) begin
            state_q <= StGrant;
            idx_q   <= selected;
            grant_q <= 8'd1 << selected;
`ifdef GRANT_DECODER_TIMEOUT_EN
            wait_q  <= 8'd0;
`endif
          end
        end
        StGrant: begin
          // Any ack outside the granted channel is flagged, whatever else happens.
          if ((ack & ~grant_q) != 8'd0) begin
            stray_q <= 1'b1;
          end
          // Priority: enable low, then granted ack, then timeout.
          if (!enable) begin
            state_q <= StIdle;
            grant_q <= 8'd0;
          end else if (ack[idx_q]) begin
            state_q    <= StIdle;
            grant_q    <= 8'd0;
            done_q     <= 1'b1;
            done_idx_q <= idx_q;
            count_q    <= count_q + 8'd1;
          end
`ifdef GRANT_DECODER_TIMEOUT_EN
          else if (wait_q == WaitLast) begin
            state_q   <= StIdle;
            grant_q   <= 8'd0;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    sel_ready   = (state_q == StIdle) && enable;
    busy        = (state_q == StGrant);
    grant       = grant_q;
    done        = done_q;
    done_idx    = done_idx_q;
    timeout     = timeout_q;
    stray_ack   = stray_q;
    grant_count = count_q;
  end

endmodule

// File: tb/tb_grant_decoder.sv
module tb_grant_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sel_valid;
  logic [2:0] selected;
  logic       sel_ready;
  logic [7:0] ack;
  logic [7:0] grant;
  logic       busy;
  logic       done;
  logic [2:0] done_idx;
  logic       timeout;
  logic       stray_ack;
  logic [7:0] grant_count;

  grant_decoder #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sel_valid  (sel_valid),
    .selected   (selected),
    .sel_ready  (sel_ready),
    .ack        (ack),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .done_idx   (done_idx),
    .timeout    (timeout),
    .stray_ack  (stray_ack),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_done;
    logic [2:0] idx;
    logic [7:0] count;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done/timeout pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (done || timeout)) begin
      exp_t e;
      chk("pulse_exclusive", 32'(done && timeout), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {31'd0, done}, {31'd0, timeout});
        errors++;
        checks++;
        $display("FAIL unexpected_event: done=%0b timeout=%0b with empty scoreboard",
                 done, timeout);
      end else begin
        e = sb_q.pop_front();
        chk("sb_kind_done", 32'(done), 32'(e.is_done));
        chk("sb_kind_timeout", 32'(timeout), 32'(!e.is_done));
        if (e.is_done) chk("sb_done_idx", 32'(done_idx), 32'(e.idx));
        chk("sb_grant_count", 32'(grant_count), 32'(e.count));
        chk("sb_grant_zero", 32'(grant), 32'd0);
        chk("sb_busy_zero", 32'(busy), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request on the first cycle sel_ready is high; return one step after accept.
  task automatic accept(input logic [2:0] idx);
    int n = 0;
    sel_valid = 1'b1;
    selected  = idx;
    while (!sel_ready && n < 20) begin
      step();
      n++;
    end
    if (!sel_ready) chk("accept_ready_timeout", 32'(sel_ready), 32'd1);
    step();
    sel_valid = 1'b0;
    chk("grant_onehot", 32'(grant), 32'(8'd1 << idx));
  endtask

  // Accept, wait `delay` grant cycles, then ack the granted channel.
  task automatic txn(input logic [2:0] idx, input int delay);
    exp_t e;
    accept(idx);
    for (int i = 0; i < delay; i++) step();
    ack = 8'd1 << idx;
    exp_count = exp_count + 8'd1;
    e.is_done = 1'b1;
    e.idx     = idx;
    e.count   = exp_count;
    sb_q.push_back(e);
    step();
    ack = 8'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; enable = 1'b0; sel_valid = 1'b0; selected = 3'd0; ack = 8'd0;
    step(); step();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_idx", 32'(done_idx), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_stray", 32'(stray_ack), 32'd0);
    chk("rst_count", 32'(grant_count), 32'd0);
    chk("ready_when_disabled", 32'(sel_ready), 32'd0);

    // Disabled block ignores requests.
    sel_valid = 1'b1; selected = 3'd4;
    step();
    chk("no_accept_disabled", 32'(busy), 32'd0);
    sel_valid = 1'b0;
    enable = 1'b1;
    step();
    chk("ready_idle", 32'(sel_ready), 32'd1);

    // Basic transaction: ch5, ack two cycles after first grant cycle.
    txn(3'd5, 2);
    #5;
    chk("txn5_done_idx", 32'(done_idx), 32'd5);
    chk("txn5_count", 32'(grant_count), 32'd1);
    #5;
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("done_idx_held", 32'(done_idx), 32'd5);

    // Request while busy is ignored; stray ack sets sticky flag.
    accept(3'd3);
    sel_valid = 1'b1; selected = 3'd6;
    chk("not_ready_busy", 32'(sel_ready), 32'd0);
    ack = 8'h81;
    step();
    ack = 8'd0;
    sel_valid = 1'b0;
    chk("stray_set", 32'(stray_ack), 32'd1);
    chk("stray_grant_kept", 32'(grant), 32'h08);
    step();
    chk("stray_sticky", 32'(stray_ack), 32'd1);
    ack = 8'h08;
    exp_count = exp_count + 8'd1;
    e.is_done = 1'b1; e.idx = 3'd3; e.count = exp_count;
    sb_q.push_back(e);
    step();
    ack = 8'd0;
    chk("stray_done_idx", 32'(done_idx), 32'd3);

    // Enable low aborts and beats a simultaneous ack.
    accept(3'd6);
    enable = 1'b0;
    ack = 8'h40;
    step();
    ack = 8'd0;
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_no_timeout", 32'(timeout), 32'd0);
    chk("abort_count", 32'(grant_count), 32'(exp_count));
    enable = 1'b1;
    step();

`ifdef GRANT_DECODER_TIMEOUT_EN
    // No ack: grant held for 16 cycles, then timeout.
    accept(3'd2);
    for (int i = 1; i <= 16; i++) begin
      chk("to_grant_held", 32'(grant), 32'h04);
      if (i == 16) begin
        e.is_done = 1'b0; e.idx = 3'd2; e.count = exp_count;
        sb_q.push_back(e);
      end
      step();
    end
    chk("to_grant_zero", 32'(grant), 32'd0);
    chk("to_no_done", 32'(done), 32'd0);
    step();
    // Granted ack on the final timeout cycle wins.
    txn(3'd7, 15);
    chk("ack_beats_timeout", 32'(timeout), 32'd0);
`else
    // No timeout: grant persists well beyond TIMEOUT cycles.
    accept(3'd2);
    for (int i = 0; i < 40; i++) step();
    chk("no_timeout_grant_held", 32'(grant), 32'h04);
    chk("no_timeout_pulse", 32'(timeout), 32'd0);
    ack = 8'h04;
    exp_count = exp_count + 8'd1;
    e.is_done = 1'b1; e.idx = 3'd2; e.count = exp_count;
    sb_q.push_back(e);
    step();
    ack = 8'd0;
`endif
    step();

    // Reset mid-grant: everything returns to reset values, no pulse.
    accept(3'd1);
    rst = 1'b1;
    ack = 8'h02;
    step();
    ack = 8'd0;
    exp_count = 8'd0;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_stray", 32'(stray_ack), 32'd0);
    chk("mid_rst_count", 32'(grant_count), 32'd0);
    chk("mid_rst_done_idx", 32'(done_idx), 32'd0);
    rst = 1'b0;
    step();

    // 256 back-to-back minimum-length transactions wrap the counter to zero.
    for (int i = 0; i < 256; i++) txn(3'(i), 0);
    step();
    chk("count_wrap", 32'(grant_count), 32'd0);
    chk("wrap_last_idx", 32'(done_idx), 32'd7);

    step(); step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_decoder.md
GRANT_DECODER -- requirements
Module: grant_decoder

Interface
REQ-001 Parameter: TIMEOUT, 16, GRANT-state cycles without acknowledge before abandonment; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  block enable; low blocks new accepts and aborts an active grant.
REQ-005 sel_valid  input  1  request: selected carries a channel index to grant.
REQ-006 selected  input  3  channel index 0..7 from the priority encoder side.
REQ-007 sel_ready  output  1  block can accept a request this cycle.
REQ-008 ack  input  8  per-channel acknowledge; bit i from channel i.
REQ-009 grant  output  8  registered one-hot grant to channel; all-zero when idle.
REQ-010 busy  output  1  high while in GRANT.
REQ-011 done  output  1  one-cycle pulse on acknowledged completion.
REQ-012 done_idx  output  3  index of the last completed grant; held until next done.
REQ-013 timeout  output  1  one-cycle pulse when a grant is abandoned for lack of ack.
REQ-014 stray_ack  output  1  sticky flag: ack seen on a non-granted channel during GRANT.
REQ-015 grant_count  output  8  completed (done) grants; wraps 255 -> 0.

Function
REQ-016 Two states: IDLE, GRANT; sel_ready = (state == IDLE) && enable, combinational from registered state.
REQ-017 Accept occurs on a cycle with sel_valid && sel_ready; selected is latched, state -> GRANT.
REQ-018 Latency: grant = 1 << latched index from the first cycle after accept; exactly one grant bit high in GRANT.
REQ-019 In GRANT, ack[latched index] high -> next cycle: state IDLE, grant 0, done pulse 1, done_idx = latched index, grant_count + 1.
REQ-020 Ack bits other than the granted one are ignored for completion; any such bit high in GRANT sets stray_ack.
REQ-021 A wait counter clears on accept and increments each GRANT cycle without granted ack; on the cycle it equals TIMEOUT-1 without ack, next cycle: state IDLE, grant 0, timeout pulse 1, no done, grant_count unchanged.
REQ-022 Granted ack and timeout in the same cycle: ack wins (done, no timeout).
REQ-023 enable low in GRANT: next cycle state IDLE, grant 0, no done, no timeout; enable has priority over ack.
REQ-024 sel_valid while not sel_ready is ignored (no queuing); requester must hold request.
REQ-025 Back-to-back: a request may be accepted on the first IDLE cycle after completion; minimum transaction = 2 cycles (accept, one grant cycle with ack).
REQ-026 done and timeout never high in the same cycle; neither asserts in IDLE except the cycle after leaving GRANT.

Reset
REQ-027 rst high on a rising edge: state IDLE, grant 0, busy 0, done 0, done_idx 0, timeout 0, stray_ack 0, grant_count 0, wait counter 0.
REQ-028 rst has priority over all inputs, including mid-GRANT; no done/timeout pulse results from reset.

Configuration
REQ-029 Macro GRANT_DECODER_TIMEOUT_EN defined: wait counter and timeout behaviour per REQ-021/022 compiled in.
REQ-030 Macro undefined: no wait counter; GRANT persists until granted ack, enable low, or reset; timeout tied 0.

Verification
REQ-031 enable 1, sel_valid 1, selected 5 at cycle 0 -> grant 8'h20 cycle 1; ack 8'h20 cycle 3 -> cycle 4 grant 0, done 1, done_idx 5, grant_count 1.
REQ-032 (TIMEOUT_EN, TIMEOUT 16) accept selected 2, no ack -> grant 8'h04 for cycles 1..16, cycle 17 grant 0, timeout 1, grant_count 0.
REQ-033 In GRANT on channel 3, ack 8'h81 -> stray_ack 1 sticky, grant stays 8'h08; later ack 8'h08 -> done, done_idx 3.
REQ-034 Mid-GRANT enable 0 -> next cycle grant 0, busy 0, no done/timeout; mid-GRANT rst 1 -> all outputs reset values next cycle.
REQ-035 Granted ack on the final timeout cycle -> done 1, timeout 0; 256 completed grants -> grant_count wraps to 0.
